// File: rtl/aer_in_rx.sv
// aer_in_rx: receive side of the AER link.
// Completes the 4-phase REQ/ACK handshake, captures each event address into a
// first-word-fall-through FIFO and presents it to the core on valid/ready.
// ACK is withheld while the FIFO is full, so the sender stalls instead of
// an event being dropped.
module aer_in_rx #(
    parameter int unsigned M          = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [M-1:0]                AERIN_ADDR,
    input  logic                        AERIN_REQ,
    output logic                        AERIN_ACK,
    output logic [M-1:0]                EVT_ADDR,
    output logic                        EVT_VALID,
    input  logic                        EVT_READY,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    output logic [CNT_W-1:0]            EVT_COUNT,
    input  logic                        CLR_COUNT
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_REQ_LOW
    } state_t;

    // Handshake side
    logic             r_req_meta;
    logic             r_req_s;
    state_t           r_state;
    logic             r_ack;

    // FIFO storage and bookkeeping
    logic [M-1:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic [CNT_W-1:0] r_evt_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_cnt_max;

    // Full is the current-cycle flag only; a simultaneous pop does not open
    // a slot for this cycle's capture, which then happens one cycle later.
    assign w_full    = (r_level == FULL_LEVEL);
    assign w_empty   = (r_level == '0);
    assign w_push    = (r_state == ST_IDLE) && r_req_s && !w_full;
    assign w_pop     = !w_empty && EVT_READY;
    assign w_cnt_max = &r_evt_count;

    assign AERIN_ACK  = r_ack;
    assign EVT_VALID  = !w_empty;
    assign EVT_ADDR   = r_mem[r_rd_ptr];
    assign FIFO_LEVEL = r_level;
    assign EVT_COUNT  = r_evt_count;

    // Two-flop synchronizer for the asynchronous REQ. The address bus is
    // bundled data and is only sampled once req_s is high, so it is stable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_req_meta <= 1'b0;
            r_req_s    <= 1'b0;
        end else begin
            r_req_meta <= AERIN_REQ;
            r_req_s    <= r_req_meta;
        end
    end

    // Handshake FSM with ACK registered directly: one capture per REQ high phase.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_req_s && !w_full) begin
                        r_ack   <= 1'b1;
                        r_state <= ST_WAIT_REQ_LOW;
                    end
                end
                ST_WAIT_REQ_LOW: begin
                    if (!r_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO storage write; contents need no reset since level gates validity.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= AERIN_ADDR;
        end
    end

    // FIFO pointers wrap naturally; level is tracked separately from them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Saturating capture counter; clear has priority over a same-cycle capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_evt_count <= '0;
        end else if (CLR_COUNT) begin
            r_evt_count <= '0;
        end else if (w_push && !w_cnt_max) begin
            r_evt_count <= r_evt_count + 1'b1;
        end
    end

endmodule

// File: doc/aer_in_rx.md
Name: aer_in_rx

Overview:
- Receive side of the 8-bit AER link driven by the accelerator's AER output stage.
- Completes the 4-phase REQ/ACK handshake with the sender and captures each event address into a first-word-fall-through FIFO.
- Presents captured events to the core on a valid/ready interface.
- Applies backpressure by withholding ACK when the FIFO is full; no event is ever dropped.

Parameters:
- M, 8: AER address width; matches sender address width.
- FIFO_DEPTH, 16: event FIFO entries; power of 2, at least 2.
- CNT_W, 16: width of the received-event counter.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; asynchronous, active-high.
- AERIN_ADDR  in  M  event address; stable while AERIN_REQ is high (bundled data).
- AERIN_REQ  in  1  request from sender; asynchronous to CLK.
- AERIN_ACK  out  1  acknowledge to sender; driven directly from a register.
- EVT_ADDR  out  M  head-of-FIFO address.
- EVT_VALID  out  1  FIFO not empty.
- EVT_READY  in  1  consumer accepts the head entry.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- EVT_COUNT  out  CNT_W  count of accepted events, saturating.
- CLR_COUNT  in  1  synchronous clear of EVT_COUNT.

Behaviour:
- Reset values:
  - AERIN_ACK=0, EVT_VALID=0, FIFO_LEVEL=0, EVT_COUNT=0.
  - EVT_ADDR is don't-care while EVT_VALID=0.
  - FSM=IDLE; read/write pointers=0; sync flops=0.
- Synchronizer: AERIN_REQ passes through 2 flops to give req_s. AERIN_ADDR is not synchronized; it is sampled only when req_s=1, so it has been stable for at least 2 cycles.
- FSM states:
  - IDLE:
    - req_s=1 and FIFO not full: write AERIN_ADDR to FIFO, AERIN_ACK<=1, go to WAIT_REQ_LOW.
    - req_s=1 and FIFO full: stay in IDLE, ACK stays 0 (stall).
    - req_s=0: stay in IDLE.
  - WAIT_REQ_LOW:
    - req_s=0: AERIN_ACK<=0, go to IDLE.
    - Otherwise hold ACK=1.
- Latency:
  - REQ rising before edge k: req_s=1 after edge k+1; capture and ACK=1 after edge k+2 (FIFO not full).
  - REQ falling: ACK=0 after 3 edges.
  - Exactly one FIFO write per REQ high phase.
- FIFO:
  - First-word fall-through: EVT_VALID=(level!=0), EVT_ADDR=mem[rd_ptr].
  - Pop on EVT_VALID&EVT_READY. Push on the capture condition.
  - Pointers wrap modulo FIFO_DEPTH; level is tracked separately.
  - Push eligibility uses the current-cycle full flag only. A pop in the same cycle does not enable a push when full; the capture occurs the next cycle.
  - Simultaneous push and pop when not full and not empty: level unchanged, both pointers advance.
  - Pop when empty is ignored.
  - A written entry is visible on EVT_VALID the cycle after the write edge.
- EVT_COUNT:
  - Increments by 1 on each capture.
  - Saturates at 2^CNT_W-1 with no wrap.
  - CLR_COUNT=1 sets it to 0 on the next edge; clear wins over a simultaneous increment.
- Reset mid-operation:
  - All state returns to reset values immediately; FIFO contents are lost and ACK drops asynchronously.
  - If the sender still holds REQ high after RST release, it is captured again as a new event. The sender shares RST, so this is accepted.
- Protocol robustness: a REQ glitch shorter than 1 cycle that is not seen by req_s is ignored. REQ dropping before ACK has no effect beyond the normal WAIT_REQ_LOW exit.

Test Plan:
- Single event: ADDR=0x5A, REQ held high until ACK, then released. Required: ACK rises 3 edges after REQ; EVT_VALID=1 with EVT_ADDR=0x5A; EVT_COUNT=1; ACK falls 3 edges after REQ falls.
- Back-to-back burst: 4-phase sender model sends 0x01,0x02,0x03 with EVT_READY=1. Required: the consumer sees 0x01,0x02,0x03 in order; FIFO_LEVEL never exceeds 1; EVT_COUNT=3.
- Backpressure: EVT_READY=0, 17 events offered with FIFO_DEPTH=16. Required: 16 ACKs, FIFO_LEVEL=16, 17th REQ gets no ACK. Then EVT_READY=1 for 1 cycle: the 17th event is captured the cycle after the pop, and its ACK follows.
- Simultaneous push/pop: level=3, capture and pop on the same edge. Required: FIFO_LEVEL stays 3 and the head advances to the next entry in order.
- Counter: force EVT_COUNT to 0xFFFF (CNT_W=16), send one event. Required: stays 0xFFFF. Then assert CLR_COUNT on the same cycle as a capture. Required: EVT_COUNT=0.
- Reset mid-handshake: assert RST while in WAIT_REQ_LOW with level=2. Required: ACK=0, EVT_VALID=0, FIFO_LEVEL=0 immediately. With REQ still high after release, the event is recaptured: ACK rises 3 edges after RST release and EVT_COUNT=1.
